// File: rtl/digit_entry.sv
// Two-digit keypad entry: edge-detected keys build a 0..99 amount, a tick-based
// timeout discards stale partial entries, and a confirmed amount is held until downstream accepts it.
module digit_entry #(
   parameter int TIMEOUT_TICKS = 10
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       tick,
   input  logic       keydown_num,
   input  logic [3:0] num,
   input  logic       keydown_clear,
   input  logic       keydown_confirm,
   input  logic       out_ready,
   output logic       out_valid,
   output logic [6:0] amount,
   output logic [3:0] tens,
   output logic [3:0] units,
   output logic [1:0] digit_count,
   output logic       editing
);
   localparam int CW = (TIMEOUT_TICKS < 2) ? 1 : $clog2(TIMEOUT_TICKS + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_TICKS - 1);

   typedef enum logic [1:0] {IDLE, ENTRY, HOLD} state_t;

   state_t          state_q, state_d;
   logic [3:0]      tens_q, tens_d, units_q, units_d;
   logic [1:0]      dc_q, dc_d;
   logic [6:0]      amount_q, amount_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic            out_valid_q, out_valid_d, editing_q, editing_d;
   logic            num_prev_q, clr_prev_q, cfm_prev_q;
   logic            dig_p, clr_p, cfm_p, wipe;

   assign clr_p = keydown_clear & ~clr_prev_q;
   assign cfm_p = keydown_confirm & ~cfm_prev_q;
   assign dig_p = keydown_num & ~num_prev_q & (num <= 4'd9);

   always_comb begin
      state_d = state_q;
      tens_d  = tens_q;
      units_d = units_q;
      dc_d    = dc_q;
      cnt_d   = cnt_q;
      wipe    = 1'b0;
      case (state_q)
         IDLE: begin
            // a same-cycle clear/confirm press swallows the digit even though they do nothing here
            if (dig_p && !clr_p && !cfm_p) begin
               units_d = num;
               tens_d  = 4'd0;
               dc_d    = 2'd1;
               cnt_d   = '0;
               state_d = ENTRY;
            end
         end
         ENTRY: begin
            if (clr_p) begin
               wipe = 1'b1;
            end else if (cfm_p) begin
               if (amount_q != 7'd0) state_d = HOLD;
               else                  wipe    = 1'b1;
            end else if (dig_p && dc_q == 2'd1) begin
               tens_d  = units_q;
               units_d = num;
               dc_d    = 2'd2;
               cnt_d   = '0;
            end else if (tick) begin
               if (cnt_q == CNT_LAST) wipe  = 1'b1;
               else                   cnt_d = cnt_q + CW'(1);
            end
         end
         HOLD: begin
            if (out_ready) wipe = 1'b1;
         end
         default: wipe = 1'b1;
      endcase
      if (wipe) begin
         state_d = IDLE;
         tens_d  = 4'd0;
         units_d = 4'd0;
         dc_d    = 2'd0;
         cnt_d   = '0;
      end
      // outputs are registered copies of next-state values
      amount_d    = 7'(tens_d) * 7'd10 + 7'(units_d);
      out_valid_d = (state_d == HOLD);
      editing_d   = (state_d == ENTRY);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         tens_q      <= 4'd0;
         units_q     <= 4'd0;
         dc_q        <= 2'd0;
         cnt_q       <= '0;
         amount_q    <= 7'd0;
         out_valid_q <= 1'b0;
         editing_q   <= 1'b0;
         num_prev_q  <= 1'b1;
         clr_prev_q  <= 1'b1;
         cfm_prev_q  <= 1'b1;
      end else begin
         state_q     <= state_d;
         tens_q      <= tens_d;
         units_q     <= units_d;
         dc_q        <= dc_d;
         cnt_q       <= cnt_d;
         amount_q    <= amount_d;
         out_valid_q <= out_valid_d;
         editing_q   <= editing_d;
         num_prev_q  <= keydown_num;
         clr_prev_q  <= keydown_clear;
         cfm_prev_q  <= keydown_confirm;
      end
   end

   assign out_valid   = out_valid_q;
   assign amount      = amount_q;
   assign tens        = tens_q;
   assign units       = units_q;
   assign digit_count = dc_q;
   assign editing     = editing_q;
endmodule

// File: tb/tb_digit_entry.sv
// Directed bench for digit_entry: a vector table for basic entry flows plus
// hand-written timeout, hold and reset sequences.
module tb_digit_entry;
   logic       clk = 1'b0;
   logic       rst_n, tick, keydown_num, keydown_clear, keydown_confirm, out_ready;
   logic [3:0] num;
   logic       out_valid, editing;
   logic [6:0] amount;
   logic [3:0] tens, units;
   logic [1:0] digit_count;

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct {
      logic       rst, tk, kn;
      logic [3:0] nm;
      logic       kc, kf, rd;
      logic       ov;
      int         amt;
      int         dc;
      logic       ed;
   } vec_t;

   vec_t tbl[$];

   digit_entry #(.TIMEOUT_TICKS(10)) dut (
      .clk(clk), .rst_n(rst_n), .tick(tick), .keydown_num(keydown_num), .num(num),
      .keydown_clear(keydown_clear), .keydown_confirm(keydown_confirm), .out_ready(out_ready),
      .out_valid(out_valid), .amount(amount), .tens(tens), .units(units),
      .digit_count(digit_count), .editing(editing)
   );

   always #5 clk = ~clk;

   function automatic vec_t v(input logic rst, tk, kn, input logic [3:0] nm,
                              input logic kc, kf, rd, input logic ov, input int amt, dc,
                              input logic ed);
      vec_t r;
      r.rst = rst; r.tk = tk; r.kn = kn; r.nm = nm; r.kc = kc; r.kf = kf; r.rd = rd;
      r.ov = ov; r.amt = amt; r.dc = dc; r.ed = ed;
      return r;
   endfunction

   task automatic chk(input string nm, input string fld, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s %s: got %0d expected %0d", nm, fld, act, exp);
      end
   endtask

   task automatic apply(input vec_t t, input string nm);
      rst_n = t.rst; tick = t.tk; keydown_num = t.kn; num = t.nm;
      keydown_clear = t.kc; keydown_confirm = t.kf; out_ready = t.rd;
      @(posedge clk); #1;
      chk(nm, "out_valid", int'(out_valid), int'(t.ov));
      chk(nm, "amount", int'(amount), t.amt);
      chk(nm, "tens", int'(tens), t.amt / 10);
      chk(nm, "units", int'(units), t.amt % 10);
      chk(nm, "digit_count", int'(digit_count), t.dc);
      chk(nm, "editing", int'(editing), int'(t.ed));
   endtask

   initial begin
      rst_n = 0; tick = 0; keydown_num = 0; num = 0;
      keydown_clear = 0; keydown_confirm = 0; out_ready = 0;

      //        rst tk kn nm  kc kf rd   ov amt dc ed
      tbl.push_back(v(0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0));  // reset
      tbl.push_back(v(1, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0));
      tbl.push_back(v(1, 0, 1, 4, 0, 0, 0,  0, 4, 1, 1));  // digit 4
      tbl.push_back(v(1, 0, 0, 0, 0, 0, 0,  0, 4, 1, 1));
      tbl.push_back(v(1, 0, 1, 2, 0, 0, 0,  0, 42, 2, 1)); // digit 2
      tbl.push_back(v(1, 0, 0, 0, 0, 0, 0,  0, 42, 2, 1));
      tbl.push_back(v(1, 0, 0, 0, 0, 1, 0,  1, 42, 2, 0)); // confirm
      tbl.push_back(v(1, 0, 0, 0, 0, 0, 1,  0, 0, 0, 0));  // transfer
      tbl.push_back(v(1, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0));
      tbl.push_back(v(1, 0, 1, 7, 0, 0, 0,  0, 7, 1, 1));  // 7,3,9,12
      tbl.push_back(v(1, 0, 0, 0, 0, 0, 0,  0, 7, 1, 1));
      tbl.push_back(v(1, 0, 1, 3, 0, 0, 0,  0, 73, 2, 1));
      tbl.push_back(v(1, 0, 0, 0, 0, 0, 0,  0, 73, 2, 1));
      tbl.push_back(v(1, 0, 1, 9, 0, 0, 0,  0, 73, 2, 1));
      tbl.push_back(v(1, 0, 0, 0, 0, 0, 0,  0, 73, 2, 1));
      tbl.push_back(v(1, 0, 1, 12, 0, 0, 0, 0, 73, 2, 1));
      tbl.push_back(v(1, 0, 0, 0, 0, 0, 0,  0, 73, 2, 1));
      tbl.push_back(v(1, 0, 0, 0, 1, 0, 0,  0, 0, 0, 0));  // clear
      tbl.push_back(v(1, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0));
      tbl.push_back(v(1, 0, 1, 12, 0, 0, 0, 0, 0, 0, 0));  // num 12 in IDLE
      tbl.push_back(v(1, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0));
      tbl.push_back(v(1, 0, 0, 0, 0, 1, 1,  0, 0, 0, 0));  // confirm in IDLE
      tbl.push_back(v(1, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0));
      tbl.push_back(v(1, 0, 1, 0, 0, 0, 0,  0, 0, 1, 1));  // digit 0
      tbl.push_back(v(1, 0, 0, 0, 0, 0, 0,  0, 0, 1, 1));
      tbl.push_back(v(1, 0, 0, 0, 0, 1, 1,  0, 0, 0, 0));  // confirm zero -> clear
      tbl.push_back(v(1, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0));
      tbl.push_back(v(1, 0, 1, 3, 0, 0, 0,  0, 3, 1, 1));  // digit 3
      tbl.push_back(v(1, 0, 0, 0, 0, 0, 0,  0, 3, 1, 1));
      tbl.push_back(v(1, 0, 1, 6, 1, 0, 0,  0, 0, 0, 0));  // clear + digit 6
      tbl.push_back(v(1, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0));
      tbl.push_back(v(0, 0, 1, 5, 0, 0, 0,  0, 0, 0, 0));  // key held over reset
      tbl.push_back(v(1, 0, 1, 5, 0, 0, 0,  0, 0, 0, 0));
      tbl.push_back(v(1, 0, 1, 5, 0, 0, 0,  0, 0, 0, 0));
      tbl.push_back(v(1, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0));

      foreach (tbl[i]) apply(tbl[i], $sformatf("vec%0d", i));

      // timeout after 10 ticks
      apply(v(1, 0, 1, 5, 0, 0, 0, 0, 5, 1, 1), "toA_press");
      apply(v(1, 0, 0, 0, 0, 0, 0, 0, 5, 1, 1), "toA_rel");
      for (int i = 1; i <= 9; i++) apply(v(1, 1, 0, 0, 0, 0, 0, 0, 5, 1, 1), $sformatf("toA_tick%0d", i));
      apply(v(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0), "toA_tick10");

      // digit restarts counter; ignored third digit does not
      apply(v(1, 0, 1, 5, 0, 0, 0, 0, 5, 1, 1), "toB_press5");
      apply(v(1, 0, 0, 0, 0, 0, 0, 0, 5, 1, 1), "toB_rel");
      for (int i = 1; i <= 9; i++) apply(v(1, 1, 0, 0, 0, 0, 0, 0, 5, 1, 1), "toB_tick");
      apply(v(1, 0, 1, 1, 0, 0, 0, 0, 51, 2, 1), "toB_press1");
      apply(v(1, 0, 0, 0, 0, 0, 0, 0, 51, 2, 1), "toB_rel1");
      for (int i = 1; i <= 9; i++) apply(v(1, 1, 0, 0, 0, 0, 0, 0, 51, 2, 1), "toB_tick2");
      apply(v(1, 0, 1, 7, 0, 0, 0, 0, 51, 2, 1), "toB_press7");
      apply(v(1, 0, 0, 0, 0, 0, 0, 0, 51, 2, 1), "toB_rel7");
      apply(v(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0), "toB_timeout");

      // digit with tick wins; confirm on the timeout tick goes to HOLD
      apply(v(1, 0, 1, 5, 0, 0, 0, 0, 5, 1, 1), "toC_press5");
      apply(v(1, 0, 0, 0, 0, 0, 0, 0, 5, 1, 1), "toC_rel");
      for (int i = 1; i <= 9; i++) apply(v(1, 1, 0, 0, 0, 0, 0, 0, 5, 1, 1), "toC_tick");
      apply(v(1, 1, 1, 1, 0, 0, 0, 0, 51, 2, 1), "toC_digit_tick");
      apply(v(1, 0, 0, 0, 0, 0, 0, 0, 51, 2, 1), "toC_rel1");
      for (int i = 1; i <= 9; i++) apply(v(1, 1, 0, 0, 0, 0, 0, 0, 51, 2, 1), "toC_tick2");
      apply(v(1, 1, 0, 0, 0, 1, 0, 1, 51, 2, 0), "toC_confirm_tick");
      apply(v(1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0), "toC_xfer");

      // HOLD stable while out_ready low, presses ignored
      apply(v(1, 0, 1, 8, 0, 0, 0, 0, 8, 1, 1), "hold_press8");
      apply(v(1, 0, 0, 0, 0, 0, 0, 0, 8, 1, 1), "hold_rel");
      apply(v(1, 0, 0, 0, 0, 1, 0, 1, 8, 1, 0), "hold_confirm");
      for (int i = 0; i < 20; i++) begin
         if (i % 2 == 0) apply(v(1, 1, 1, 3, (i % 4 == 0), 0, 0, 1, 8, 1, 0), "hold_press");
         else            apply(v(1, 0, 0, 0, 0, 1, 0, 1, 8, 1, 0), "hold_idle");
      end
      apply(v(1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0), "hold_xfer");
      apply(v(1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0), "hold_after");

      // reset during HOLD with 99
      apply(v(1, 0, 1, 9, 0, 0, 0, 0, 9, 1, 1), "rst_p9a");
      apply(v(1, 0, 0, 0, 0, 0, 0, 0, 9, 1, 1), "rst_rela");
      apply(v(1, 0, 1, 9, 0, 0, 0, 0, 99, 2, 1), "rst_p9b");
      apply(v(1, 0, 0, 0, 0, 0, 0, 0, 99, 2, 1), "rst_relb");
      apply(v(1, 0, 0, 0, 0, 1, 0, 1, 99, 2, 0), "rst_confirm");
      apply(v(1, 0, 0, 0, 0, 0, 0, 1, 99, 2, 0), "rst_hold");
      apply(v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), "rst_in_hold");
      apply(v(1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0), "rst_release");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
